// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and constants for the instruction memory loader
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [6:0] END_OPC_DEFAULT = 7'h7F;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader that holds the CPU until the program is written
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W  = 5,
  parameter logic [6:0] END_OPC = END_OPC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_idx;
  logic [31:0]       word_q;
  logic              err_q;
  logic              accept;
  logic              is_end;
  logic              at_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign accept     = rx_valid && rx_ready;
  assign is_end     = (word_q[6:0] == END_OPC);
  assign at_last    = (addr_q == {ADDR_W{1'b1}});
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    imem_wren = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_COLLECT;
      end
      ST_COLLECT: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_idx == LAST_BYTE_IDX) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        imem_wren = 1'b1;
        if (is_end) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = ST_CHECK;
`else
          state_nx = ST_DONE;
`endif
        end else if (at_last) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_COLLECT;
        end
      end
      ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        rx_ready = 1'b1;
        if (rx_valid) state_nx = ST_DONE;
`else
        state_nx = ST_DONE;
`endif
      end
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nx = ST_COLLECT;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Byte assembler, address counter and status; start only matters when not mid-load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_q   <= '0;
            byte_idx <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            word_q[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_q + rx_data;
`endif
          end
        end
        ST_WRITE: begin
          if (!is_end) begin
            if (at_last) begin
              err_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) err_q <= (rx_data != sum_q);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
